uart_alu_pkt_parser: RTL and testbench

- Byte-stream packet parser between uart_rx and the ALU datapath inside uart_alu.
- Consumes 8-bit AXI-stream bytes from uart_rx and decodes a 4-byte header: opcode, reserved, length LSB, length MSB.
- Packs the payload into little-endian 32-bit operands and presents them to the ALU on a valid/ready interface, with first/last framing.
- Drops malformed or stalled packets and flags them on an error output, so the ALU only ever sees well-formed operand streams.

---
 rtl/uart_alu_pkt_parser_if.sv | 35 +++
 rtl/uart_alu_pkt_parser.sv | 180 ++++++++++++++++++
 tb/tb_uart_alu_pkt_parser.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_alu_pkt_parser_if.sv
// Byte-stream in / operand-stream out bundle of the UART ALU packet parser.
// Latency: none (signal bundle only).
// Backpressure: rx side rx_valid_i/rx_ready_o, ALU side operand_valid_o/operand_ready_i.
// Ports: rx_data_i, rx_valid_i, rx_ready_o          byte stream from uart_rx
//        opcode_o, operand_o, operand_valid_o,
//        operand_ready_i, operand_first_o,
//        operand_last_o                             operand stream to the ALU
//        err_o, err_code_o                          packet-drop notification
interface uart_alu_pkt_parser_if;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [7:0]  opcode_o;
  logic [31:0] operand_o;
  logic        operand_valid_o;
  logic        operand_ready_i;
  logic        operand_first_o;
  logic        operand_last_o;
  logic        err_o;
  logic [1:0]  err_code_o;

  // Parser side.
  modport slave (
    input  rx_data_i, rx_valid_i, operand_ready_i,
    output rx_ready_o, opcode_o, operand_o, operand_valid_o,
           operand_first_o, operand_last_o, err_o, err_code_o
  );

  // Environment side: uart_rx feeding bytes, ALU consuming operands.
  modport master (
    output rx_data_i, rx_valid_i, operand_ready_i,
    input  rx_ready_o, opcode_o, operand_o, operand_valid_o,
           operand_first_o, operand_last_o, err_o, err_code_o
  );
endinterface

// File: rtl/uart_alu_pkt_parser.sv
// Decodes opcode/rsvd/len_lo/len_hi packets and packs the payload into 32-bit ALU operands.
// Latency: operand valid 1 cycle after its last byte; err_o 1 cycle after the deciding byte/idle cycle.
// Backpressure: rx_ready_o low while an operand waits for the ALU; byte stream otherwise never stalls.
// Ports: clk_i      system clock
//        rst_ni     asynchronous active-low reset
//        bus        uart_alu_pkt_parser_if.slave (rx byte stream, operand stream, error flags)
module uart_alu_pkt_parser #(
  parameter logic [15:0] MAX_LEN_P = 16'd1024,
  parameter logic [31:0] TIMEOUT_P = 32'd100000
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  uart_alu_pkt_parser_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_RSVD, S_LEN_LO, S_LEN_HI, S_PAYLOAD, S_EMIT, S_DRAIN
  } state_t;

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hA0;
  localparam logic [7:0] OP_MUL  = 8'hA1;
  localparam logic [7:0] OP_DIV  = 8'hA2;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_op_hdr;       // opcode of the packet being parsed
  logic        r_bad_op;
  logic [7:0]  r_len_lo;
  logic [15:0] r_cnt;          // payload bytes still to accept (PAYLOAD/DRAIN)
  logic [31:0] r_tmo;
  logic [23:0] r_pack;         // lower three bytes of the operand under assembly
  logic [1:0]  r_idx;          // byte lane of the next payload byte
  logic        r_first_pend;
  logic [7:0]  r_opcode;
  logic [31:0] r_operand;
  logic        r_valid, r_first, r_last, r_err;
  logic [1:0]  r_err_code;

  logic        w_rx_ready, w_xfer, w_op_xfer, w_tmo_act, w_tmo_hit;
  logic        w_rx_op_ok, w_is_arith, w_len_bad, w_hdr_bad, w_op_done;
  logic [15:0] w_len, w_pay;
  logic        w_err_set, w_load_op;
  logic [1:0]  w_err_code_nxt;

  assign w_rx_ready = (r_state != S_EMIT);
  assign w_xfer     = bus.rx_valid_i && w_rx_ready;
  assign w_op_xfer  = r_valid && bus.operand_ready_i;

  assign w_rx_op_ok = bus.rx_data_i inside {OP_ECHO, OP_ADD, OP_MUL, OP_DIV};
  assign w_is_arith = r_op_hdr inside {OP_ADD, OP_MUL, OP_DIV};
  assign w_len      = {bus.rx_data_i, r_len_lo};
  assign w_pay      = w_len - 16'd4;
  // P mod 4 only matters once L >= 5, where w_pay cannot underflow.
  assign w_len_bad  = (w_len < 16'd5) || (w_len > MAX_LEN_P) ||
                      (w_is_arith && (w_pay[1:0] != 2'b00));
  assign w_hdr_bad  = r_bad_op || w_len_bad;
  assign w_op_done  = (r_op_hdr == OP_ECHO) || (r_idx == 2'd3);

  // Idle-cycle watchdog runs only while a packet is partly received; EMIT is
  // excluded so a slow ALU never aborts a packet.
  assign w_tmo_act  = (r_state != S_IDLE) && (r_state != S_EMIT);
  assign w_tmo_hit  = w_tmo_act && !w_xfer && (r_tmo == TIMEOUT_P - 32'd1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_err_set      = 1'b0;
    w_err_code_nxt = r_err_code;
    w_load_op      = 1'b0;
    if (w_tmo_hit) begin
      w_state_nxt    = S_IDLE;
      w_err_set      = 1'b1;
      w_err_code_nxt = 2'b11;
    end else begin
      case (r_state)
        S_IDLE:   if (w_xfer) w_state_nxt = S_RSVD;
        S_RSVD:   if (w_xfer) w_state_nxt = S_LEN_LO;
        S_LEN_LO: if (w_xfer) w_state_nxt = S_LEN_HI;
        S_LEN_HI: if (w_xfer) begin
          if (w_hdr_bad) begin
            w_err_set      = 1'b1;
            w_err_code_nxt = r_bad_op ? 2'b01 : 2'b10;
            w_state_nxt    = (w_len <= 16'd4) ? S_IDLE : S_DRAIN;
          end else begin
            w_state_nxt = S_PAYLOAD;
          end
        end
        S_PAYLOAD: if (w_xfer && w_op_done) begin
          w_load_op   = 1'b1;
          w_state_nxt = S_EMIT;
        end
        S_EMIT:   if (w_op_xfer) w_state_nxt = (r_cnt != 16'd0) ? S_PAYLOAD : S_IDLE;
        S_DRAIN:  if (w_xfer && (r_cnt == 16'd1)) w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_op_hdr     <= 8'd0;
      r_bad_op     <= 1'b0;
      r_len_lo     <= 8'd0;
      r_cnt        <= 16'd0;
      r_tmo        <= 32'd0;
      r_pack       <= 24'd0;
      r_idx        <= 2'd0;
      r_first_pend <= 1'b0;
      r_opcode     <= 8'd0;
      r_operand    <= 32'd0;
      r_valid      <= 1'b0;
      r_first      <= 1'b0;
      r_last       <= 1'b0;
      r_err        <= 1'b0;
      r_err_code   <= 2'b00;
    end else begin
      r_err <= w_err_set;
      if (w_err_set) r_err_code <= w_err_code_nxt;

      if (w_tmo_act && !w_xfer && !w_tmo_hit) r_tmo <= r_tmo + 32'd1;
      else                                    r_tmo <= 32'd0;

      if ((r_state == S_IDLE) && w_xfer) begin
        r_op_hdr <= bus.rx_data_i;
        r_bad_op <= !w_rx_op_ok;
      end
      if ((r_state == S_LEN_LO) && w_xfer) r_len_lo <= bus.rx_data_i;

      // A fresh header restarts packing, which also discards any partial
      // operand left behind by a timeout abort.
      if ((r_state == S_LEN_HI) && w_xfer) begin
        r_cnt        <= (w_len <= 16'd4) ? 16'd0 : w_pay;
        r_idx        <= 2'd0;
        r_pack       <= 24'd0;
        r_first_pend <= 1'b1;
      end

      if (((r_state == S_PAYLOAD) || (r_state == S_DRAIN)) && w_xfer)
        r_cnt <= r_cnt - 16'd1;

      if ((r_state == S_PAYLOAD) && w_xfer) begin
        r_idx <= r_idx + 2'd1;
        case (r_idx)
          2'd0:    r_pack[7:0]   <= bus.rx_data_i;
          2'd1:    r_pack[15:8]  <= bus.rx_data_i;
          2'd2:    r_pack[23:16] <= bus.rx_data_i;
          default: ;
        endcase
      end

      if (w_load_op) begin
        r_operand    <= (r_op_hdr == OP_ECHO) ? {24'd0, bus.rx_data_i}
                                              : {bus.rx_data_i, r_pack};
        r_opcode     <= r_op_hdr;
        r_valid      <= 1'b1;
        r_first      <= r_first_pend;
        r_last       <= (r_cnt == 16'd1);
        r_first_pend <= 1'b0;
      end else if (w_op_xfer) begin
        r_valid <= 1'b0;
        r_first <= 1'b0;
        r_last  <= 1'b0;
      end
    end
  end

  assign bus.rx_ready_o      = w_rx_ready;
  assign bus.opcode_o        = r_opcode;
  assign bus.operand_o       = r_operand;
  assign bus.operand_valid_o = r_valid;
  assign bus.operand_first_o = r_first;
  assign bus.operand_last_o  = r_last;
  assign bus.err_o           = r_err;
  assign bus.err_code_o      = r_err_code;

endmodule

// File: tb/tb_uart_alu_pkt_parser.sv
// Directed bench for uart_alu_pkt_parser: packets are fed byte by byte, a
// packet-level model predicts operands and error codes, and a negedge monitor
// checks every operand handshake and error pulse against those predictions.
module tb_uart_alu_pkt_parser;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [7:0]  op;
    logic [31:0] val;
    logic        first;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_alu_pkt_parser_if pif();

  uart_alu_pkt_parser #(
    .MAX_LEN_P(16'd1024),
    .TIMEOUT_P(32'd200)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (pif)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  exp_t        exp_q[$];
  logic [1:0]  err_q[$];
  logic [31:0] got_log[$];
  int          n_ops_done = 0;
  int          n_stall = 0;
  int          stall_target = -1;
  int          stall_left = 0;
  logic        hold_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, want);
  endtask

  // Packet-level reference: what a whole packet must produce.
  task automatic model_pkt(input byte_q_t pkt);
    logic [7:0] op;
    int         len, pay, step, nops;
    bit         arith;
    logic [31:0] v;
    op    = pkt[0];
    len   = {pkt[3], pkt[2]};
    pay   = len - 4;
    arith = (op == 8'hA0) || (op == 8'hA1) || (op == 8'hA2);
    if (!arith && op != 8'hEC) begin
      err_q.push_back(2'b01);
    end else if (len < 5 || len > 1024 || (arith && (pay % 4) != 0)) begin
      err_q.push_back(2'b10);
    end else begin
      step = arith ? 4 : 1;
      nops = pay / step;
      for (int i = 0; i < nops; i++) begin
        v = 32'd0;
        for (int k = 0; k < step; k++) v = v | (32'(pkt[4 + i*step + k]) << (8*k));
        exp_q.push_back('{op, v, (i == 0), (i == nops - 1)});
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the edge that took the byte.
  task automatic send_byte(input logic [7:0] b, output int n);
    logic rdy;
    n = 0;
    pif.rx_data_i  = b;
    pif.rx_valid_i = 1'b1;
    forever begin
      @(negedge clk);
      rdy = pif.rx_ready_o;
      @(posedge clk);
      #1;
      n++;
      if (rdy) break;
      if (n >= 500) begin
        n_chk++;
        $display("FAIL byte_accept: byte %h still not taken after %0d cycles, expected acceptance", b, n);
        break;
      end
    end
    pif.rx_valid_i = 1'b0;
  endtask

  task automatic send_raw(input byte_q_t pkt);
    int n;
    foreach (pkt[i]) send_byte(pkt[i], n);
  endtask

  task automatic send_pkt(input byte_q_t pkt);
    model_pkt(pkt);
    send_raw(pkt);
  endtask

  task automatic settle(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
    check("exp_ops_left", exp_q.size(), 0);
    check("exp_errs_left", err_q.size(), 0);
  endtask

  // ALU-side ready: optionally held low, or stalled for a while on one operand.
  always @(posedge clk) begin
    #1;
    if (hold_ready) pif.operand_ready_i = 1'b0;
    else if (pif.operand_valid_o && n_ops_done == stall_target && stall_left > 0) begin
      pif.operand_ready_i = 1'b0;
      stall_left--;
    end else pif.operand_ready_i = 1'b1;
  end

  // Monitor: every cycle out of reset.
  logic        prev_hold = 1'b0;
  logic [31:0] prev_operand;
  exp_t        e;
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      prev_hold = 1'b0;
    end else begin
      check("rx_ready_vs_emit", pif.rx_ready_o, !pif.operand_valid_o);
      if (prev_hold) begin
        check("hold_valid", pif.operand_valid_o, 1'b1);
        check("hold_operand", pif.operand_o, prev_operand);
      end
      if (pif.operand_valid_o && !pif.operand_ready_i) n_stall++;
      if (pif.operand_valid_o && pif.operand_ready_i) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_operand: got %h, expected no operand", pif.operand_o);
        end else begin
          e = exp_q.pop_front();
          check("operand", pif.operand_o, e.val);
          check("opcode", pif.opcode_o, e.op);
          check("first", pif.operand_first_o, e.first);
          check("last", pif.operand_last_o, e.last);
        end
        got_log.push_back(pif.operand_o);
        n_ops_done++;
      end
      if (pif.err_o) begin
        if (err_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_err: err_o=1 code %b, expected no error", pif.err_code_o);
        end else check("err_code", pif.err_code_o, err_q.pop_front());
      end
      prev_hold    = pif.operand_valid_o && !pif.operand_ready_i;
      prev_operand = pif.operand_o;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t p;
    int      n, k_err;
    rst_n          = 1'b0;
    pif.rx_data_i  = 8'd0;
    pif.rx_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_rx_ready", pif.rx_ready_o, 1'b1);
    check("rst_valid", pif.operand_valid_o, 1'b0);
    check("rst_operand", pif.operand_o, 32'd0);
    check("rst_opcode", pif.opcode_o, 8'd0);
    check("rst_first_last", {pif.operand_first_o, pif.operand_last_o}, 2'b00);
    check("rst_err", {pif.err_o, pif.err_code_o}, 3'b000);

    // Two add operands, ALU always ready.
    got_log.delete();
    p = {8'hA0, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
    send_pkt(p);
    settle(5);
    check("A_nops", got_log.size(), 2);
    if (got_log.size() == 2) begin
      check("A_op0", got_log[0], 32'h0000_0005);
      check("A_op1", got_log[1], 32'h0000_0007);
    end

    // Echo with a 50-cycle stall on the second operand.
    got_log.delete();
    n_stall      = 0;
    stall_target = n_ops_done + 1;
    stall_left   = 50;
    p = {8'hEC, 8'h00, 8'h07, 8'h00, 8'h48, 8'h69, 8'h21};
    send_pkt(p);
    settle(5);
    check("echo_stall_cycles", n_stall, 50);
    check("echo_nops", got_log.size(), 3);
    if (got_log.size() == 3) begin
      check("echo_op0", got_log[0], 32'h48);
      check("echo_op1", got_log[1], 32'h69);
      check("echo_op2", got_log[2], 32'h21);
    end

    // Bad length: 6-byte payload on mul; every drained byte taken at once.
    got_log.delete();
    p = {8'hA1, 8'h00, 8'h0A, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    model_pkt(p);
    foreach (p[i]) begin
      send_byte(p[i], n);
      if (i >= 4) check("drain_1cycle", n, 1);
    end
    p = {8'hA0, 8'h00, 8'h08, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_pkt(p);
    settle(5);
    check("badlen_err_code_held", pif.err_code_o, 2'b10);
    check("badlen_nops", got_log.size(), 1);
    if (got_log.size() == 1) check("after_badlen_op", got_log[0], 32'hDDCC_BBAA);

    // Bad opcode, then a too-short header, then a good divide packet.
    got_log.delete();
    p = {8'h55, 8'h00, 8'h08, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_pkt(p);
    settle(3);
    check("badop_err_code_held", pif.err_code_o, 2'b01);
    check("badop_nops", got_log.size(), 0);
    p = {8'hA0, 8'h00, 8'h03, 8'h00};
    send_pkt(p);
    settle(3);
    check("short_err_code", pif.err_code_o, 2'b10);
    p = {8'hA2, 8'h00, 8'h08, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00};
    send_pkt(p);
    settle(5);
    check("short_nops", got_log.size(), 1);
    if (got_log.size() == 1) check("after_short_op", got_log[0], 32'h10);

    // Timeout mid-payload: error must appear exactly 200 idle cycles later.
    got_log.delete();
    p = {8'hA0, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00};
    err_q.push_back(2'b11);
    send_raw(p);
    k_err = -1;
    for (int k = 1; k <= 220; k++) begin
      @(posedge clk);
      #2;
      if (pif.err_o && k_err < 0) k_err = k;
    end
    check("tmo_cycle", k_err, 200);
    check("tmo_err_code", pif.err_code_o, 2'b11);
    p = {8'hA1, 8'h00, 8'h08, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    send_pkt(p);
    settle(5);
    check("tmo_nops", got_log.size(), 1);
    if (got_log.size() == 1) check("after_tmo_op", got_log[0], 32'h0403_0201);

    // Reset while an operand is waiting in EMIT.
    hold_ready = 1'b1;
    p = {8'hA0, 8'h00, 8'h08, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send_raw(p);
    @(posedge clk);
    #1;
    check("pre_rst_valid", pif.operand_valid_o, 1'b1);
    check("pre_rst_operand", pif.operand_o, 32'h4433_2211);
    check("pre_rst_rx_ready", pif.rx_ready_o, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_valid", pif.operand_valid_o, 1'b0);
    check("rst_async_rx_ready", pif.rx_ready_o, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    hold_ready = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_rx_ready", pif.rx_ready_o, 1'b1);
    check("post_rst_valid", pif.operand_valid_o, 1'b0);
    got_log.delete();
    p = {8'hEC, 8'h00, 8'h05, 8'h00, 8'h7E};
    send_pkt(p);
    settle(5);
    check("post_rst_nops", got_log.size(), 1);
    if (got_log.size() == 1) check("post_rst_op", got_log[0], 32'h7E);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
